// File: rtl/bus_copy_pkg.sv
// Shared types and constants for the bus copy master.
package bus_copy_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_LA,
      RD,
      WR_LA,
      WR,
      FIN
   } state_e;

   localparam logic [3:0]  WSTRB_READ = 4'b0000;
   localparam logic [3:0]  WSTRB_WORD = 4'b1111;
   localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/bus_copy_master_if.sv
// PicoRV32 native memory bus, including the look-ahead address/strobes.
interface bus_copy_master_if;

   logic        mem_valid;
   logic        mem_instr;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_la_read;
   logic        mem_la_write;
   logic [31:0] mem_la_addr;

   modport master (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_la_read, mem_la_write, mem_la_addr,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_la_read, mem_la_write, mem_la_addr,
      output mem_ready, mem_rdata
   );

endinterface

// File: rtl/bus_copy_master.sv
// Word-by-word block copier acting as a PicoRV32-style bus master.
// Optional macro BUS_COPY_TIMEOUT_EN adds a per-transfer ready timeout with a sticky error flag.
module bus_copy_master
   import bus_copy_pkg::*;
#(
   parameter int LEN_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 i_start,
   input  logic [31:0]          i_src_addr,
   input  logic [31:0]          i_dst_addr,
   input  logic [LEN_WIDTH-1:0] i_len,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_error,
   bus_copy_master_if.master    bus
);

   localparam logic [31:0] ADDR_MASK = ~32'd3;

   state_e               state_q, state_d;
   logic [31:0]          src_q, src_d;
   logic [31:0]          dst_q, dst_d;
   logic [31:0]          buf_q, buf_d;
   logic [LEN_WIDTH-1:0] rem_q, rem_d;
   logic                 valid_q, valid_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [3:0]           wstrb_q, wstrb_d;
   logic                 ack;
   logic                 timeout_hit;

   assign ack = valid_q & bus.mem_ready;

`ifdef BUS_COPY_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              error_q, error_d;

   // The wait counter restarts at every look-ahead cycle, so each transfer gets its own budget.
   assign timeout_hit = ((state_q == RD) || (state_q == WR)) && !ack &&
                        (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wait_d  = wait_q;
      error_d = error_q;
      if ((state_q == IDLE) && i_start) begin
         error_d = 1'b0;
      end else if (timeout_hit) begin
         error_d = 1'b1;
      end
      if ((state_q == RD_LA) || (state_q == WR_LA)) begin
         wait_d = '0;
      end else if (((state_q == RD) || (state_q == WR)) && !ack && !timeout_hit) begin
         wait_d = wait_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wait_q  <= '0;
         error_q <= 1'b0;
      end else begin
         wait_q  <= wait_d;
         error_q <= error_d;
      end
   end

   assign o_error = error_q;
`else
   assign timeout_hit = 1'b0;
   assign o_error     = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      buf_d   = buf_q;
      rem_d   = rem_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               if (i_len != '0) begin
                  src_d   = i_src_addr & ADDR_MASK;
                  dst_d   = i_dst_addr & ADDR_MASK;
                  rem_d   = i_len;
                  state_d = RD_LA;
               end else begin
                  state_d = FIN;
               end
            end
         end
         RD_LA: begin
            valid_d = 1'b1;
            addr_d  = src_q;
            wstrb_d = WSTRB_READ;
            state_d = RD;
         end
         RD: begin
            if (ack) begin
               buf_d   = bus.mem_rdata;
               valid_d = 1'b0;
               state_d = WR_LA;
            end else if (timeout_hit) begin
               valid_d = 1'b0;
               state_d = FIN;
            end
         end
         WR_LA: begin
            valid_d = 1'b1;
            addr_d  = dst_q;
            wdata_d = buf_q;
            wstrb_d = WSTRB_WORD;
            state_d = WR;
         end
         WR: begin
            // Addresses wrap mod 2^32 naturally through the 32-bit adders.
            if (ack) begin
               src_d   = src_q + WORD_BYTES;
               dst_d   = dst_q + WORD_BYTES;
               rem_d   = rem_q - 1'b1;
               valid_d = 1'b0;
               state_d = (rem_q == LEN_WIDTH'(1)) ? FIN : RD_LA;
            end else if (timeout_hit) begin
               valid_d = 1'b0;
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         buf_q   <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= WSTRB_READ;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         buf_q   <= buf_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
      end
   end

   // Look-ahead outputs announce next cycle's transfer, matching what the CPU presents to bus_mux.
   assign bus.mem_la_read  = (state_q == RD_LA);
   assign bus.mem_la_write = (state_q == WR_LA);
   assign bus.mem_la_addr  = (state_q == RD_LA) ? src_q :
                             (state_q == WR_LA) ? dst_q : 32'd0;

   assign bus.mem_valid = valid_q;
   assign bus.mem_instr = 1'b0;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wstrb = wstrb_q;

   assign o_busy = (state_q != IDLE);
   assign o_done = (state_q == FIN);

endmodule
